machine_host_ctrl: RTL and testbench

Host-side sequencer that drives the `machine` image processor's status/addr/data port protocol from byte streams. It accepts a raw image as a valid/ready byte stream and writes it into `machine` (status 10). It then starts processing (status 01), waits for `end_process`, reads the result back (status 11) and emits it as a valid/ready byte stream. It sits directly upstream and downstream of `machine`, replacing the manual stimulus sequencing at system level.

---
 rtl/machine_pkg.sv | 11 +
 rtl/machine_host_ctrl.sv | 115 +++++++++++
 tb/tb_machine_host_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/machine_pkg.sv
// Shared definitions for the machine image processor status/addr/data port protocol.
package machine_pkg;

   localparam logic [1:0] ST_HOLD = 2'b00;
   localparam logic [1:0] ST_PROC = 2'b01;
   localparam logic [1:0] ST_LOAD = 2'b10;
   localparam logic [1:0] ST_READ = 2'b11;

   typedef enum logic [2:0] {IDLE, LOAD, PROC, READ, DONE} state_t;

endpackage

// File: rtl/machine_host_ctrl.sv
// Host-side sequencer: streams an image into machine, runs it, and streams the
// result back out, translating valid/ready handshakes into the status/addr/data protocol.
module machine_host_ctrl
   import machine_pkg::*;
#(
   parameter int IN_PIXELS  = 65536,
   parameter int OUT_PIXELS = 16384,
   parameter int ADDR_W     = 16,
   parameter int READ_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic [1:0]        status,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data,
   input  logic              end_process,
   input  logic [7:0]        out,
   output logic              busy,
   output logic              done
);

   localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_PIXELS - 1);
   localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_PIXELS - 1);
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(READ_LAT - 1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [LAT_W-1:0]  lat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat       <= '0;
         status    <= ST_HOLD;
         addr      <= '0;
         data      <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               // addr/data only move on an accepted byte, so gaps simply rewrite the held pixel
               if (in_valid && in_ready) begin
                  addr   <= cnt;
                  data   <= in_data;
                  status <= ST_LOAD;
                  cnt    <= cnt + ADDR_W'(1);
                  if (cnt == IN_LAST) begin
                     in_ready <= 1'b0;
                     state    <= PROC;
                  end
               end
            end
            PROC: begin
               status <= ST_PROC;
               if (end_process) begin
                  state  <= READ;
                  status <= ST_READ;
                  addr   <= '0;
                  lat    <= '0;
               end
            end
            READ: begin
               // addr doubles as the output pixel index; lat paces the machine read pipeline
               if (out_valid) begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     lat       <= '0;
                     if (addr == OUT_LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        status <= ST_HOLD;
                        addr   <= '0;
                     end else begin
                        addr <= addr + ADDR_W'(1);
                     end
                  end
               end else if (lat == LAT_LAST) begin
                  out_data  <= out;
                  out_valid <= 1'b1;
               end else begin
                  lat <= lat + LAT_W'(1);
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_machine_host_ctrl.sv
// Bench for machine_host_ctrl with a small behavioural machine model that averages
// four input bytes into each result byte.
module tb_machine_host_ctrl;
   import machine_pkg::*;

   localparam int IN_PIXELS  = 16;
   localparam int OUT_PIXELS = 4;
   localparam int ADDR_W     = 16;
   localparam int READ_LAT   = 2;
   localparam int GRP        = IN_PIXELS / OUT_PIXELS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic              out_ready = 1'b0;
   logic [1:0]        status;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              end_process = 1'b0;
   logic [7:0]        out = 8'h00;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   logic [7:0] mem  [IN_PIXELS];
   logic [7:0] sent [IN_PIXELS];
   logic [7:0] exp_q[$];

   typedef struct {
      logic       vld;
      logic [7:0] din;
      int         exp_addr;
      logic [7:0] exp_data;
      logic [1:0] exp_status;
      logic       exp_rdy;
   } vec_t;
   vec_t vec[IN_PIXELS+2];

   always #5 clk = ~clk;

   machine_host_ctrl #(
      .IN_PIXELS (IN_PIXELS),
      .OUT_PIXELS(OUT_PIXELS),
      .ADDR_W    (ADDR_W),
      .READ_LAT  (READ_LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .status     (status),
      .addr       (addr),
      .data       (data),
      .end_process(end_process),
      .out        (out),
      .busy       (busy),
      .done       (done)
   );

   function automatic logic [7:0] avg(input int k);
      int s = 0;
      for (int j = 0; j < GRP; j++) s += int'(mem[k*GRP+j]);
      return 8'(s / GRP);
   endfunction

   // Behavioural machine: writes in status 10, one-register read path gives READ_LAT=2
   always @(posedge clk) begin
      if (status == ST_LOAD) mem[int'(addr) % IN_PIXELS] <= data;
      out <= avg(int'(addr) % OUT_PIXELS);
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input int i, input logic [7:0] b);
      int s = 0;
      sent[i] = b;
      if (i % GRP == GRP - 1) begin
         for (int j = i - GRP + 1; j <= i; j++) s += int'(sent[j]);
         exp_q.push_back(8'(s / GRP));
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_status"}, status, ST_HOLD);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   task automatic chk_mem();
      for (int i = 0; i < IN_PIXELS; i++) chk("model_mem", mem[i], sent[i]);
   endtask

   task automatic load(input bit gapped);
      logic [7:0] b;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_in_ready", in_ready, 1);
      for (int i = 0; i < IN_PIXELS; i++) begin
         if (gapped) begin
            in_valid = 1'b0;
            tick();
            if (i > 0) begin
               chk("gap_addr_hold", addr, i - 1);
               chk("gap_data_hold", data, sent[i-1]);
               chk("gap_status", status, ST_LOAD);
            end
         end
         b = 8'($urandom_range(0, 255));
         push_byte(i, b);
         in_valid = 1'b1;
         in_data  = b;
         tick();
         chk("load_addr", addr, i);
         chk("load_data", data, b);
         chk("load_status", status, ST_LOAD);
      end
      in_valid = 1'b0;
      tick();
      chk("proc_status", status, ST_PROC);
      chk_mem();
   endtask

   task automatic proc_read(input int stall_pix, input int stop_after);
      int         waited;
      int         done_before;
      logic [7:0] held;
      done_before = done_cnt;
      // Spurious start and in_valid while waiting on the machine
      for (int c = 0; c < 4; c++) begin
         start    = (c == 1);
         in_valid = (c == 2);
         tick();
         chk("proc_hold_status", status, ST_PROC);
         chk("proc_hold_addr", addr, IN_PIXELS - 1);
         chk("proc_in_ready", in_ready, 0);
      end
      start       = 1'b0;
      in_valid    = 1'b0;
      end_process = 1'b1;
      tick();
      end_process = 1'b0;
      chk("read_status", status, ST_READ);
      chk("read_addr0", addr, 0);
      in_valid = 1'b1;
      for (int k = 0; k < OUT_PIXELS; k++) begin
         waited = 0;
         while (!out_valid && waited < 20) begin
            tick();
            waited++;
         end
         chk("read_latency", waited, READ_LAT);
         chk("read_addr", addr, k);
         if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
         else chk("out_data", out_data, exp_q.pop_front());
         if (k == stop_after) return;
         if (k == stall_pix) begin
            held = out_data;
            for (int s = 0; s < 3; s++) begin
               tick();
               chk("stall_valid", out_valid, 1);
               chk("stall_data", out_data, held);
               chk("stall_addr", addr, k);
            end
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("hs_valid_low", out_valid, 0);
         if (k < OUT_PIXELS - 1) begin
            chk("next_addr", addr, k + 1);
         end else begin
            chk("done_pulse", done, 1);
            chk("done_status", status, ST_HOLD);
            chk("done_addr", addr, 0);
         end
      end
      in_valid = 1'b0;
      tick();
      chk("done_low", done, 0);
      chk("idle_busy", busy, 0);
      chk("done_count", done_cnt - done_before, 1);
   endtask

   initial begin
      for (int i = 0; i < IN_PIXELS; i++) begin
         mem[i]  = 8'h00;
         sent[i] = 8'h00;
      end
      for (int i = 0; i < IN_PIXELS; i++)
         vec[i] = '{1'b1, 8'(8'h10 + i), i, 8'(8'h10 + i), ST_LOAD, (i < IN_PIXELS - 1)};
      vec[IN_PIXELS]   = '{1'b0, 8'h00, IN_PIXELS - 1, 8'h1F, ST_PROC, 1'b0};
      vec[IN_PIXELS+1] = '{1'b1, 8'hEE, IN_PIXELS - 1, 8'h1F, ST_PROC, 1'b0};

      // Reset, then idle with no start
      repeat (3) tick();
      chk_reset_vals("reset");
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_status", status, ST_HOLD);
         chk("idle_addr", addr, 0);
         chk("idle_in_ready", in_ready, 0);
         chk("idle_busy", busy, 0);
      end

      // Back-to-back load from the vector table; start and end_process together in IDLE
      start       = 1'b1;
      end_process = 1'b1;
      tick();
      start       = 1'b0;
      end_process = 1'b0;
      chk("start_ep_status", status, ST_HOLD);
      chk("start_ep_busy", busy, 1);
      chk("start_ep_in_ready", in_ready, 1);
      for (int i = 0; i < IN_PIXELS + 2; i++) begin
         in_valid = vec[i].vld;
         in_data  = vec[i].din;
         if (vec[i].vld && i < IN_PIXELS) push_byte(i, vec[i].din);
         tick();
         chk("vec_addr", addr, vec[i].exp_addr);
         chk("vec_data", data, vec[i].exp_data);
         chk("vec_status", status, vec[i].exp_status);
         chk("vec_in_ready", in_ready, vec[i].exp_rdy);
      end
      in_valid = 1'b0;
      chk_mem();
      proc_read(1, -1);

      // Gapped input, stall on the last pixel
      load(1'b1);
      proc_read(3, -1);

      // Reset in the middle of READ once pixel 2 is presented
      load(1'b0);
      proc_read(-1, 2);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_reset");
      exp_q.delete();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_reset_busy", busy, 0);
      chk("post_reset_status", status, ST_HOLD);

      // Fresh full run after the abort
      load(1'b0);
      proc_read(0, -1);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
